// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial divider.
//   DEFAULT_WIDTH : default operand/result width
//   state_e       : controller states with fixed 2-bit encoding
//   cnt_width()   : bit counter width, clog2(width) but never below 1
package serial_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/subtract_step.sv
// One restoring-division trial subtraction on WIDTH+1 bits.
//   minuend    : shifted partial remainder
//   subtrahend : zero-extended divisor
//   diff       : minuend - subtrahend (modulo 2^(WIDTH+1))
//   borrow     : high when subtrahend > minuend
module subtract_step
  import serial_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};
  end

endmodule

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   CLK100MHZ  : clock, rising edge
//   CPU_RESETN : synchronous active-low reset
//   START      : request, only looked at in IDLE
//   A, B       : dividend / divisor, captured when START is accepted
//   Q, R       : registered quotient / remainder, held between results
//   BUSY       : high while iterating (RUN)
//   DONE       : one-cycle pulse while Q/R/DZ present a fresh result (FIN)
//   DZ         : last result was a divide by zero (Q = all ones, R = A)
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DZ
);

  localparam int unsigned    cnt_w    = cnt_width(WIDTH);
  localparam logic [cnt_w-1:0] cnt_init = cnt_w'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  // Datapath for one RUN step
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dividend_step;
  logic             unused_diff_msb;

  assign shifted = {rem_q, dividend_q[WIDTH-1]};

  subtract_step #(
    .WIDTH(WIDTH)
  ) u_subtract_step (
    .minuend   (shifted),
    .subtrahend({1'b0, divisor_q}),
    .diff      (diff),
    .borrow    (borrow)
  );

  assign q_bit    = ~borrow;
  // Without a borrow the difference is below the divisor, so its MSB is always zero.
  assign rem_step = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

  // The dividend register doubles as the quotient accumulator: consumed dividend bits
  // leave at the top while quotient bits enter at the bottom.
  assign dividend_step = (dividend_q << 1) | WIDTH'(q_bit);

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    dz_d       = dz_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (B == '0) begin
            // Divide by zero skips iteration and publishes straight away.
            state_d = FIN;
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
          end else begin
            state_d    = RUN;
            dividend_d = A;
            divisor_d  = B;
            rem_d      = '0;
            cnt_d      = cnt_init;
          end
        end
      end
      RUN: begin
        rem_d      = rem_step;
        dividend_d = dividend_step;
        if (cnt_q == '0) begin
          state_d = FIN;
          q_d     = dividend_step;
          r_d     = rem_step;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - cnt_w'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider (WIDTH = 4): a cycle-level behavioural model
// checked against the DUT every cycle, plus directed vectors with literal results.
module tb_serial_divider;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] div_a, div_b;
  logic [W-1:0] q, r;
  logic         busy, done, dz;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  serial_divider #(
    .WIDTH(W)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .START     (start),
    .A         (div_a),
    .B         (div_b),
    .Q         (q),
    .R         (r),
    .BUSY      (busy),
    .DONE      (done),
    .DZ        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a division accepted in idle finishes WIDTH clocks later with
  // a/b, a%b (or all-ones, a, dz for b==0 right away); DONE lasts one clock and one
  // further clock passes before the next request can be taken.
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_dz = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  int           m_wait = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0; m_busy <= 1'b0; m_wait <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      m_busy <= (m_wait > 1);
      if (m_wait == 1) begin
        m_q <= p_q; m_r <= p_r; m_dz <= 1'b0; m_done <= 1'b1;
      end
    end else if (start) begin
      if (div_b == 0) begin
        m_q <= '1; m_r <= div_a; m_dz <= 1'b1; m_done <= 1'b1;
      end else begin
        p_q <= div_a / div_b; p_r <= div_a % div_b; m_wait <= W; m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_q", q, m_q);
      check("cyc_r", r, m_r);
      check("cyc_dz", dz, m_dz);
    end
  end

  // Call just after a negedge: presents a request for exactly one rising edge.
  task automatic launch(input int a, input int b);
    div_a = W'(a);
    div_b = W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Latency counts clock cycles from the accepting edge to the first DONE sample.
  task automatic expect_result(input string name, input int eq, input int er, input int edz,
                               input int elat);
    int n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, n, elat);
    check({name, "_q"}, q, eq);
    check({name, "_r"}, r, er);
    check({name, "_dz"}, dz, edz);
  endtask

  task automatic do_div(input string name, input int a, input int b, input int eq,
                        input int er, input int edz, input int elat);
    @(negedge clk);
    launch(a, b);
    expect_result(name, eq, er, edz, elat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, last, pulses;
    rst_n = 1'b0;
    start = 1'b0;
    div_a = '0;
    div_b = '0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    rst_n = 1'b1;

    // Literal vectors; a divide by zero publishes in the cycle right after acceptance.
    do_div("d13_3", 13, 3, 4, 1, 0, 5);
    do_div("d7_0", 7, 0, 15, 7, 1, 1);
    do_div("d9_2", 9, 2, 4, 1, 0, 5);
    do_div("d15_1", 15, 1, 15, 0, 0, 5);
    do_div("d2_9", 2, 9, 0, 2, 0, 5);
    do_div("d6_6", 6, 6, 1, 0, 0, 5);

    // START held high; operands scrambled whenever the divider is iterating.
    @(negedge clk);
    div_a = 4'd14;
    div_b = 4'd4;
    start = 1'b1;
    cyc = 0;
    last = 0;
    pulses = 0;
    while (pulses < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        div_a = W'($urandom);
        div_b = W'($urandom);
      end else begin
        div_a = 4'd14;
        div_b = 4'd4;
      end
      if (done) begin
        check("held_q", q, 3);
        check("held_r", r, 2);
        if (pulses > 0) check("held_period", cyc - last, 6);
        last = cyc;
        pulses++;
      end
    end
    check("held_pulses", pulses, 3);
    start = 1'b0;

    // Reset during RUN abandons the division; a request is taken on the first edge after.
    @(negedge clk);
    launch(13, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_q", q, 0);
    check("mid_rst_r", r, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dz", dz, 0);
    rst_n = 1'b1;
    launch(10, 3);
    expect_result("after_rst", 3, 1, 0, 5);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_div("sweep", a, b, 15, a, 1, 1);
        else        do_div("sweep", a, b, a / b, a % b, 0, 5);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
